// File: rtl/vslc_pkg.sv
// Shared constants, state encoding and width helpers for the VSLC scan sequencer.
package vslc_pkg;

    localparam int unsigned DEF_ADDR_W     = 8;
    localparam int unsigned DEF_GAP_CYCLES = 16;
    localparam int unsigned DEF_WDT_LIMIT  = 1023;
    localparam int unsigned SCAN_CNT_W     = 16;

    // Program terminator; consumed by the sequencer, never issued.
    localparam logic [7:0] END_OP = 8'hFF;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_SNAP  = 3'd1;
    localparam state_t S_FETCH = 3'd2;
    localparam state_t S_ISSUE = 3'd3;
    localparam state_t S_END   = 3'd4;
    localparam state_t S_GAP   = 3'd5;

    // Bits needed to hold the larger of two down-counter load values.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/vslc_scan_gap_timer.sv
// Loadable down-counter with a zero flag; times inter-scan gaps and the scan watchdog.
module vslc_scan_gap_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/vslc_scan_sequencer.sv
// Scan-cycle controller: snapshot inputs, fetch and issue the program once per scan.
// Optional scan watchdog enabled by defining VSLC_SCAN_WDT_EN.
module vslc_scan_sequencer
    import vslc_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned WDT_LIMIT  = DEF_WDT_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  step,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_valid,
    input  logic [7:0]            ui_in,
    output logic [7:0]            ui_snap,
    output logic [7:0]            ui_prev,
    output logic [7:0]            instr,
    output logic                  instr_ready,
    output logic [ADDR_W-1:0]     pc,
    output logic                  running,
    output logic                  scan_done,
    output logic [SCAN_CNT_W-1:0] scan_count,
    output logic                  wdt_trip
);

    localparam int unsigned CNT_W    = cnt_width(GAP_CYCLES, WDT_LIMIT);
    localparam int unsigned GAP_LOAD = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_W-1:0]       r_pc, w_pc_nxt;
    logic [7:0]              r_instr, w_instr_nxt;
    logic [7:0]              r_ui_snap, w_ui_snap_nxt;
    logic [7:0]              r_ui_prev, w_ui_prev_nxt;
    logic                    r_one_shot, w_one_shot_nxt;
    logic                    r_wdt_trip, w_wdt_trip_nxt;
    logic [SCAN_CNT_W-1:0]   r_scan_count;
    logic                    r_mem_req, r_instr_ready, r_scan_done, r_running;
    logic                    w_gap_load, w_gap_dec, w_gap_zero;

    vslc_scan_gap_timer #(.W(CNT_W)) u_gap_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_gap_load),
        .i_load_val (CNT_W'(GAP_LOAD)),
        .i_dec      (w_gap_dec),
        .o_zero_c   (w_gap_zero)
    );

`ifdef VSLC_SCAN_WDT_EN
    localparam int unsigned WDT_LOAD = (WDT_LIMIT == 0) ? 0 : WDT_LIMIT - 1;
    logic w_wdt_load, w_wdt_dec, w_wdt_zero;

    vslc_scan_gap_timer #(.W(CNT_W)) u_wdt_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_wdt_load),
        .i_load_val (CNT_W'(WDT_LOAD)),
        .i_dec      (w_wdt_dec),
        .o_zero_c   (w_wdt_zero)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_ui_snap_nxt  = r_ui_snap;
        w_ui_prev_nxt  = r_ui_prev;
        w_one_shot_nxt = r_one_shot;
        w_wdt_trip_nxt = r_wdt_trip;
        w_gap_load     = 1'b0;
        w_gap_dec      = 1'b0;
`ifdef VSLC_SCAN_WDT_EN
        w_wdt_load     = 1'b0;
        w_wdt_dec      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // After a watchdog trip, run must be seen low before scanning resumes.
                if (r_wdt_trip) begin
                    if (!run) w_wdt_trip_nxt = 1'b0;
                end else if (run || step) begin
                    w_state_nxt    = S_SNAP;
                    w_one_shot_nxt = !run;
                end
            end
            S_SNAP: begin
                w_ui_prev_nxt = r_ui_snap;
                w_ui_snap_nxt = ui_in;
                w_pc_nxt      = '0;
                w_state_nxt   = S_FETCH;
`ifdef VSLC_SCAN_WDT_EN
                w_wdt_load    = 1'b1;
`endif
            end
            S_FETCH: begin
                if (mem_valid) begin
                    if (mem_rdata == END_OP) begin
                        w_state_nxt = S_END;
                    end else begin
                        w_instr_nxt = mem_rdata;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (r_pc == '1) begin
                    w_state_nxt = S_END;
                end else begin
                    w_pc_nxt    = r_pc + ADDR_W'(1);
                    w_state_nxt = S_FETCH;
                end
            end
            S_END: begin
                if (r_one_shot || !run) begin
                    w_state_nxt    = S_IDLE;
                    w_one_shot_nxt = 1'b0;
                end else if (GAP_CYCLES == 0) begin
                    w_state_nxt = S_SNAP;
                end else begin
                    w_gap_load  = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (!run) begin
                    w_state_nxt = S_IDLE;
                end else if (w_gap_zero) begin
                    w_state_nxt = S_SNAP;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef VSLC_SCAN_WDT_EN
        // Watchdog abort overrides whatever the scan was about to do.
        if ((r_state == S_FETCH) || (r_state == S_ISSUE)) begin
            if (w_wdt_zero) begin
                w_state_nxt    = S_IDLE;
                w_wdt_trip_nxt = 1'b1;
                w_one_shot_nxt = 1'b0;
            end else begin
                w_wdt_dec = 1'b1;
            end
        end
`endif
    end

    // Outputs are registered from the next state so they align with it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= '0;
            r_instr       <= '0;
            r_ui_snap     <= '0;
            r_ui_prev     <= '0;
            r_one_shot    <= 1'b0;
            r_wdt_trip    <= 1'b0;
            r_scan_count  <= '0;
            r_mem_req     <= 1'b0;
            r_instr_ready <= 1'b0;
            r_scan_done   <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_ui_snap     <= w_ui_snap_nxt;
            r_ui_prev     <= w_ui_prev_nxt;
            r_one_shot    <= w_one_shot_nxt;
            r_wdt_trip    <= w_wdt_trip_nxt;
            r_scan_count  <= r_scan_count + SCAN_CNT_W'(w_state_nxt == S_END);
            r_mem_req     <= (w_state_nxt == S_FETCH);
            r_instr_ready <= (w_state_nxt == S_ISSUE);
            r_scan_done   <= (w_state_nxt == S_END);
            r_running     <= (w_state_nxt != S_IDLE);
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_ready = r_instr_ready;
    assign ui_snap     = r_ui_snap;
    assign ui_prev     = r_ui_prev;
    assign running     = r_running;
    assign scan_done   = r_scan_done;
    assign scan_count  = r_scan_count;
    assign wdt_trip    = r_wdt_trip;

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Directed bench: main instance with no gap, second instance with a 3-clock gap and WDT_LIMIT=10.
module tb_vslc_scan_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Main instance (GAP_CYCLES=0) and its memory model
    logic       run, step, mem_req, mem_valid, instr_ready, running, scan_done, wdt_trip;
    logic [7:0] mem_addr, mem_rdata, ui_in, ui_snap, ui_prev, instr, pc;
    logic [15:0] scan_count;
    logic [7:0] prog [256];
    int         lat;
    int         r_wait;

    assign mem_rdata = prog[mem_addr];
    assign mem_valid = mem_req && (r_wait >= lat);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_wait <= 0;
        else if (mem_req && !mem_valid) r_wait <= r_wait + 1;
        else                           r_wait <= 0;
    end

    vslc_scan_sequencer #(.ADDR_W(8), .GAP_CYCLES(0), .WDT_LIMIT(1023)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .ui_in(ui_in), .ui_snap(ui_snap), .ui_prev(ui_prev), .instr(instr),
        .instr_ready(instr_ready), .pc(pc), .running(running), .scan_done(scan_done),
        .scan_count(scan_count), .wdt_trip(wdt_trip)
    );

    logic [7:0] issued [$];
    always @(negedge clk) if (instr_ready) issued.push_back(instr);

    // Gap instance (GAP_CYCLES=3, program {0x5A, END})
    logic       run_g, mem_req_g, mem_valid_g, instr_ready_g, running_g, scan_done_g, wdt_trip_g;
    logic       g_block;
    logic [7:0] mem_addr_g, mem_rdata_g, ui_snap_g, ui_prev_g, instr_g, pc_g;
    logic [15:0] scan_count_g;

    assign mem_rdata_g = (mem_addr_g == 8'd0) ? 8'h5A : 8'hFF;
    assign mem_valid_g = mem_req_g && !g_block;

    vslc_scan_sequencer #(.ADDR_W(8), .GAP_CYCLES(3), .WDT_LIMIT(10)) u_gap (
        .clk(clk), .rst_n(rst_n), .run(run_g), .step(1'b0),
        .mem_req(mem_req_g), .mem_addr(mem_addr_g), .mem_rdata(mem_rdata_g), .mem_valid(mem_valid_g),
        .ui_in(8'h00), .ui_snap(ui_snap_g), .ui_prev(ui_prev_g), .instr(instr_g),
        .instr_ready(instr_ready_g), .pc(pc_g), .running(running_g), .scan_done(scan_done_g),
        .scan_count(scan_count_g), .wdt_trip(wdt_trip_g)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Advance until the selected instance pulses scan_done, bounded by limit clocks.
    task automatic wait_done(input bit g, input string tag, input int limit, output int at);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            tick(1);
            n++;
            seen = g ? scan_done_g : scan_done;
        end
        check(tag, 32'(seen), 32'd1);
        at = cyc;
    endtask

    initial begin
        int t0, t1, n;
        rst_n = 1'b0; run = 1'b0; step = 1'b0; ui_in = 8'h00; lat = 0;
        run_g = 1'b0; g_block = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = 8'hFF;
        prog[0] = 8'h08; prog[1] = 8'h90; prog[2] = 8'hFF;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        check("rst_running", 32'(running), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_outputs", {instr, ui_snap, ui_prev, pc}, 0);
        check("rst_strobes", {instr_ready, scan_done, wdt_trip, running_g}, 0);
        check("rst_count", 32'(scan_count), 0);

        // Back-to-back scans, two-clock issue spacing, snapshot pipeline
        ui_in = 8'h01; run = 1'b1;
        tick(1);
        check("t1_snap_running", 32'(running), 1);
        check("t1_snap_no_req", 32'(mem_req), 0);
        tick(1);
        check("t1_ui_snap", 32'(ui_snap), 32'h01);
        check("t1_ui_prev", 32'(ui_prev), 32'h00);
        check("t1_fetch_req", {mem_req, mem_addr}, {1'b1, 8'h00});
        tick(1);
        check("t1_issue0", {instr_ready, instr}, {1'b1, 8'h08});
        ui_in = 8'h55;
        tick(1);
        check("t1_fetch1", {instr_ready, mem_req, mem_addr}, {1'b0, 1'b1, 8'h01});
        tick(1);
        check("t1_issue1", {instr_ready, instr}, {1'b1, 8'h90});
        tick(2);
        check("t1_end", {scan_done, instr_ready, instr}, {1'b1, 1'b0, 8'h90});
        check("t1_count1", 32'(scan_count), 1);
        check("t1_snap_stable", 32'(ui_snap), 32'h01);
        ui_in = 8'h03;
        tick(1);
        check("t1_resnap", {scan_done, running}, {1'b0, 1'b1});
        tick(1);
        check("t1_scan2_snap", {ui_snap, ui_prev}, {8'h03, 8'h01});
        tick(5);
        check("t1_end2", {scan_done, scan_count}, {1'b1, 16'd2});
        run = 1'b0;
        tick(1);
        check("t1_idle", 32'(running), 0);
        check("t1_issued_n", 32'(issued.size()), 4);
        check("t1_issued_3", 32'(issued[3]), 32'h90);

        // Single step with run low
        issued.delete();
        ui_in = 8'h07; step = 1'b1;
        tick(1);
        step = 1'b0;
        wait_done(1'b0, "t2_done", 20, t0);
        check("t2_count", 32'(scan_count), 3);
        tick(1);
        check("t2_idle", 32'(running), 0);
        tick(5);
        check("t2_stays_idle", {running, scan_count}, {1'b0, 16'd3});
        check("t2_issued_n", 32'(issued.size()), 2);
        check("t2_ui", {ui_snap, ui_prev}, {8'h07, 8'h03});

        // Slow memory; run and step together means continuous scanning
        issued.delete();
        lat = 5; run = 1'b1; step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold%0d", i), {mem_req, mem_addr, instr_ready}, {1'b1, 8'h00, 1'b0});
            tick(1);
        end
        tick(1);
        check("t3_issue_after_valid", {instr_ready, instr}, {1'b1, 8'h08});
        wait_done(1'b0, "t3_done1", 40, t0);
        tick(1);
        check("t3_continues", 32'(running), 1);
        lat = 0; run = 1'b0;
        wait_done(1'b0, "t3_done2", 20, t0);
        tick(1);
        check("t3_idle", {running, scan_count}, {1'b0, 16'd5});
        check("t3_issued_n", 32'(issued.size()), 4);

        // run dropped during the second of four instructions
        issued.delete();
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h44; prog[4] = 8'hFF;
        run = 1'b1;
        n = 0;
        while (!(instr_ready && instr == 8'h22) && n < 30) begin
            tick(1);
            n++;
        end
        check("t4_saw_22", {instr_ready, instr}, {1'b1, 8'h22});
        run = 1'b0;
        wait_done(1'b0, "t4_done", 20, t0);
        check("t4_issued_n", 32'(issued.size()), 4);
        check("t4_issued_last", 32'(issued[3]), 32'h44);
        tick(1);
        check("t4_idle", {running, scan_count}, {1'b0, 16'd6});

        // No END_OP: address wrap terminates the scan after 256 issues
        issued.delete();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
        step = 1'b1;
        tick(1);
        step = 1'b0;
        wait_done(1'b0, "t5_done", 700, t0);
        check("t5_issued_n", 32'(issued.size()), 256);
        check("t5_pc_end", 32'(pc), 32'hFF);
        tick(1);
        check("t5_idle", {running, scan_count}, {1'b0, 16'd7});

        // Asynchronous reset while waiting in FETCH
        prog[0] = 8'h08; prog[1] = 8'hFF;
        lat = 5; run = 1'b1;
        tick(3);
        check("t6_in_fetch", 32'(mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_req", 32'(mem_req), 0);
        check("t6_async_state", {running, scan_count}, 0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issued.delete();
        tick(4);
        check("t6_no_issue", 32'(issued.size()), 0);
        check("t6_quiet", {running, mem_req}, 0);

        // Gap instance: scan period = 5 active clocks + 3 gap clocks
        lat = 0; run_g = 1'b1;
        wait_done(1'b1, "t7_done1", 20, t0);
        wait_done(1'b1, "t7_done2", 20, t1);
        check("t7_period", 32'(t1 - t0), 8);
        check("t7_count_instr", {scan_count_g, instr_g}, {16'd2, 8'h5A});
        tick(1);
        run_g = 1'b0;
        tick(1);
        check("t7_gap_abort", 32'(running_g), 0);

`ifdef VSLC_SCAN_WDT_EN
        // Memory never answers: watchdog trips after 10 FETCH clocks
        g_block = 1'b1; run_g = 1'b1;
        tick(11);
        check("t8_pre_trip", {wdt_trip_g, mem_req_g}, {1'b0, 1'b1});
        tick(1);
        check("t8_trip", {wdt_trip_g, running_g, mem_req_g, scan_done_g}, {1'b1, 1'b0, 1'b0, 1'b0});
        check("t8_count_kept", 32'(scan_count_g), 2);
        tick(3);
        check("t8_held_off", {wdt_trip_g, running_g}, {1'b1, 1'b0});
        run_g = 1'b0;
        tick(1);
        check("t8_cleared", 32'(wdt_trip_g), 0);
        g_block = 1'b0; run_g = 1'b1;
        wait_done(1'b1, "t8_resume", 20, t0);
        check("t8_resume_count", {wdt_trip_g, scan_count_g}, {1'b0, 16'd3});
        run_g = 1'b0;
        tick(12);
`else
        check("t8_wdt_tied", {wdt_trip, wdt_trip_g}, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/vslc_scan_sequencer.md
Name: vslc_scan_sequencer

Overview:
- Scan-cycle controller for the VSLC executor. Each scan it snapshots inputs, fetches instructions in order from program memory, and issues them one per handshake.
- Drives the executor's `instr`, `instr_ready`, `ui_in` and `ui_in_prev` inputs.
- Provides run, stop and single-scan control.
- Updates on posedge `clk`. The executor samples on negedge, so `instr` and `instr_ready` are stable half a cycle before use.

Parameters:
- ADDR_W, 8, program-memory address width; max program length is 2^ADDR_W.
- GAP_CYCLES, 16, idle clocks inserted between consecutive scans (0 = back-to-back).
- WDT_LIMIT, 1023, max clocks per scan before watchdog trip (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = scan continuously.
- step  in  1  single-cycle pulse; run exactly one scan from IDLE.
- mem_req  out  1  fetch request, held until mem_valid.
- mem_addr  out  ADDR_W  fetch address (= pc).
- mem_rdata  in  8  fetched instruction byte.
- mem_valid  in  1  mem_rdata valid this cycle.
- ui_in  in  8  raw inputs.
- ui_snap  out  8  inputs latched at scan start; goes to executor ui_in.
- ui_prev  out  8  previous scan's snapshot; goes to executor ui_in_prev.
- instr  out  8  instruction to executor.
- instr_ready  out  1  one-cycle issue strobe.
- pc  out  ADDR_W  current program counter.
- running  out  1  1 in any state other than IDLE.
- scan_done  out  1  one-cycle pulse at end of each scan.
- scan_count  out  16  completed scans, wraps at 0xFFFF -> 0.
- wdt_trip  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0. Reset mid-fetch or mid-issue drops mem_req and instr_ready immediately. No partial instruction is issued after release.
- END_OP = 8'hFF, defined in the package. It is not forwarded to the executor.
- IDLE:
  - run=1 or step=1 -> SNAP.
  - The step request is latched as one_shot=1.
  - run and step in the same cycle: run wins; one_shot=0.
- SNAP (1 cycle): ui_prev<=ui_snap; ui_snap<=ui_in; pc<=0 -> FETCH.
  - The first scan after reset therefore has ui_prev=0.
- FETCH:
  - mem_req=1, mem_addr=pc, held until mem_valid. The wait is unbounded.
  - On mem_valid with rdata==END_OP -> END.
  - Otherwise instr<=rdata -> ISSUE.
- ISSUE (1 cycle):
  - instr_ready=1.
  - If pc==all-ones -> END (address wrap terminates the scan).
  - Else pc<=pc+1 -> FETCH.
- END (1 cycle):
  - scan_done=1; scan_count+=1.
  - If one_shot or run=0 -> IDLE; clear one_shot.
  - Elif GAP_CYCLES==0 -> SNAP.
  - Else load gap counter -> GAP.
- GAP: decrement each cycle; at 0 -> SNAP. If run falls during GAP -> IDLE next cycle.
- run falling mid-scan: the scan always completes (scans are atomic); then IDLE.
- step while running: ignored.
- Throughput: minimum 2 clocks per instruction (FETCH with same-cycle mem_valid, then ISSUE). instr_ready rises the cycle after mem_valid.
- instr holds its last value outside ISSUE. instr_ready is 0 outside ISSUE.
- ui_snap and ui_prev change only in SNAP, so inputs are constant for a whole scan.

Optional Feature:
- Macro: VSLC_SCAN_WDT_EN.
- With the macro:
  - A per-scan clock counter clears in SNAP and counts in FETCH/ISSUE.
  - When it reaches WDT_LIMIT, the scan aborts: state -> IDLE, mem_req=0, no scan_done, scan_count unchanged, wdt_trip=1 (sticky).
  - While wdt_trip=1, IDLE ignores run until run has been observed low. That low observation clears wdt_trip.
- Without the macro: no counter; wdt_trip tied 0.

Decomposition:
- Shared package vslc_pkg: END_OP constant; state enum {IDLE, SNAP, FETCH, ISSUE, END, GAP}; default widths.
- One natural sub-module: vslc_scan_gap_timer, a loadable down-counter with a zero flag, reused by the watchdog.

Test Plan:
- Program {0x08, 0x90, 0xFF}, mem_valid same-cycle, run=1, GAP_CYCLES=0 -> instr_ready pulses with 0x08 then 0x90, 2 clocks apart; scan_done 1 cycle later; next SNAP follows immediately; scan_count increments each scan.
- ui_in=0x01 in scan 1, 0x03 in scan 2 -> during scan 2 ui_snap=0x03 and ui_prev=0x01. Changing ui_in mid-scan leaves ui_snap unchanged.
- step pulse with run=0 -> exactly one scan, scan_count=1, return to IDLE, running=0.
- mem_valid delayed 5 clocks per fetch -> mem_req/mem_addr held stable for all 5 clocks; no instr_ready until valid.
- run dropped during the 2nd instruction of a 4-instruction program -> remaining instructions still issued, scan_done pulses, then IDLE. Reset asserted mid-FETCH -> mem_req=0 asynchronously.
- VSLC_SCAN_WDT_EN, WDT_LIMIT=10, mem_valid never asserted -> after 10 clocks wdt_trip=1, IDLE, no scan_done. run low then high -> wdt_trip clears and scanning resumes.
